ecg_stream_ctrl: RTL and testbench
==================================

# ecg_stream_ctrl

Sample-stream controller that sits between the UART byte interfaces and the ECG FIR cascade in the filter top level. It assembles received bytes into signed samples and feeds them to the filter with a one-cycle advance strobe. It waits out the filter latency, captures, scales and saturates the result, then serialises it back to the UART transmitter byte by byte. It owns resynchronisation, overrun detection and transmit handshaking, replacing the direct RX-to-TX loopback.

## Interface
Parameters:
- DATAWIDTH, 64, filter datapath width (FiltIn/FiltOut).
- SAMPLEWIDTH, 16, UART sample width in bits; must be a multiple of 8. NBYTES = SAMPLEWIDTH/8.
- OUTSHIFT, 31, arithmetic right shift applied to FiltOut before saturation.
- FILTLAT, 2, cycles from sample_en to valid FiltOut (≥1).
- TIMEOUT, 50000, maximum idle cycles between bytes of one sample.

Ports:
- Clk  in  1  single clock.
- nRst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte, valid when rx_ready=1.
- rx_ready  in  1  one-cycle byte-valid pulse.
- tx_data  out  8  byte to transmit.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  transmitter busy.
- FiltIn  out  DATAWIDTH  sign-extended sample to filter.
- sample_en  out  1  one-cycle filter advance strobe.
- FiltOut  in  DATAWIDTH  filter result.
- overrun  out  1  sticky: a sample was dropped.
- sat  out  1  sticky: an output was saturated.
- drop_cnt  out  16  dropped-sample count, saturates at 0xFFFF.

## Operation
- Reset: every output is 0. Assembly index, timers and FSM are cleared. Any in-progress byte or sample is abandoned and tx_start deasserts immediately.
- Assembler runs independently of the main FSM.
  - Bytes arrive little-endian. A byte index counts 0..NBYTES-1.
  - On each rx_ready the byte is stored at the index and the idle timer clears.
  - When the index is nonzero and the idle timer reaches TIMEOUT, the index returns to 0 and the partial sample is discarded.
  - On the final byte the sample is complete.
- Main FSM states:
  - IDLE: on sample complete, register FiltIn = sign-extended sample, go to FEED.
  - FEED: sample_en=1 for one cycle; load latency counter with FILTLAT-1; go to WAIT.
  - WAIT: count down; at 0 capture FiltOut; go to SCALE.
  - SCALE: v = FiltOut >>> OUTSHIFT. If v > 2^(SW-1)-1, result = max positive and sat is set. If v < -2^(SW-1), result = min negative and sat is set. Otherwise result = v[SW-1:0]. Byte pointer = 0; go to SEND.
  - SEND: when tx_busy=0, drive tx_data = result byte[ptr] and tx_start=1 for one cycle; go to GUARD.
  - GUARD: one cycle with tx_busy ignored. If ptr = NBYTES-1, go to IDLE; otherwise ptr++ and go to SEND.
- Overrun: a sample completes while the FSM is not in IDLE (including the cycle in which the FSM returns to IDLE).
  - The sample is dropped.
  - overrun is set and drop_cnt increments.
  - FiltIn is unchanged.
- If a sample completes while nRst is low, it is ignored.

## Timing
- sample_en is asserted the cycle after the rx_ready of the final byte, and FiltIn is valid in that same cycle.
- FiltOut is sampled at the edge FILTLAT cycles after the sample_en cycle.
- The first tx_start comes at the earliest 2 cycles after capture (SCALE, then SEND) when tx_busy=0.
- Consecutive tx_start pulses are at least 2 cycles apart. A tx_start is never issued while tx_busy=1 is observed in SEND.
- The timeout boundary is exact. A byte arriving when the idle timer equals TIMEOUT-1 is accepted; the timer reaching TIMEOUT discards the partial sample.
- If rx_ready arrives in the same cycle the timer expires, the byte is taken as byte 0 of a new sample.
- Sticky flags and drop_cnt clear only on reset.

## Structure
- Package ecg_pkg holds:
  - the main-FSM state enum (IDLE, FEED, WAIT, SCALE, SEND, GUARD);
  - saturation helper constants derived from SAMPLEWIDTH.
- Sub-module ecg_byte_assembler: index counter, byte register and timeout timer. It outputs the assembled sample and a complete pulse.
- The main FSM and scaler live in ecg_stream_ctrl.

## Test plan
Defaults unless noted; OUTSHIFT=16 in scenarios 2–3; the filter model is a FILTLAT-deep register pipe; TX model is busy 10 cycles after each start.
- rx bytes 0x34, 0x12 -> FiltIn = 0x0000_0000_0000_1234 with one sample_en pulse exactly 1 cycle after the second rx_ready; bytes 0xFE, 0xFF -> FiltIn = 0xFFFF_FFFF_FFFF_FFFE.
- FiltOut = 0x0000_0000_5678_0000 -> tx bytes 0x78 then 0x56, each tx_start issued only with tx_busy=0; sat stays 0.
- FiltOut = 0x0000_0001_0000_0000 -> tx 0xFF, 0x7F and sat=1. FiltOut = 0xFFFF_FFFF_0000_0000 -> tx 0x00, 0x80.
- Byte 0x34, then no bytes for TIMEOUT cycles, then 0x12, 0x00 -> a single sample 0x0012 (TIMEOUT set to 100 for sim).
- Second sample completes during SEND -> no second sample_en, overrun=1, drop_cnt=1, and the first output still transmits both bytes.
- nRst low during GUARD of byte 0 -> all outputs 0 within the reset cycle; after release, sample 0x0001 is processed normally.

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared types and saturation helpers for the ECG sample-stream controller.
package ecg_pkg;

    // Main controller states.
    typedef enum logic [2:0] {
        StIdle,
        StFeed,
        StWait,
        StScale,
        StSend,
        StGuard
    } ecg_state_e;

    // Widest word the saturation helpers are built in; callers truncate.
    localparam int unsigned SatCalcWidth = 128;

    // Largest positive value of a signed sample of width sw: 2^(sw-1)-1.
    function automatic logic [SatCalcWidth-1:0] sat_pos(input int unsigned sw);
        sat_pos = (SatCalcWidth'(1) << (sw - 1)) - SatCalcWidth'(1);
    endfunction

    // Most negative value of a signed sample of width sw: -2^(sw-1).
    function automatic logic [SatCalcWidth-1:0] sat_neg(input int unsigned sw);
        sat_neg = ~sat_pos(sw);
    endfunction

endpackage

// File: rtl/ecg_stream_ctrl_if.sv
// UART byte and filter datapath signals between the stream controller and its neighbours.
interface ecg_stream_ctrl_if #(
    parameter int unsigned DATAWIDTH = 64
);
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [DATAWIDTH-1:0] FiltIn;
    logic                 sample_en;
    logic [DATAWIDTH-1:0] FiltOut;

    // Controller side.
    modport master (
        input  rx_data, rx_ready, tx_busy, FiltOut,
        output tx_data, tx_start, FiltIn, sample_en
    );

    // UART / filter side.
    modport slave (
        output rx_data, rx_ready, tx_busy, FiltOut,
        input  tx_data, tx_start, FiltIn, sample_en
    );
endinterface

// File: rtl/ecg_byte_assembler.sv
// Collects little-endian UART bytes into one sample; drops a partial sample after an idle gap.
module ecg_byte_assembler #(
    parameter int unsigned SAMPLEWIDTH = 16,
    parameter int unsigned TIMEOUT     = 50000
) (
    input  logic                   Clk,
    input  logic                   nRst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic [SAMPLEWIDTH-1:0] sample,
    output logic                   complete
);
    localparam int NBYTES = int'(SAMPLEWIDTH / 8);
    localparam int IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TimerW = $clog2(TIMEOUT + 1);

    logic [IdxW-1:0]        idx_q, idx_d, eff_idx;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [SAMPLEWIDTH-1:0] data_q, data_d;
    logic                   expire;

    // Byte placement, idle timer and timeout; a byte in the expiry cycle starts a new sample.
    always_comb begin
        expire   = (idx_q != '0) && (timer_q == TimerW'(TIMEOUT));
        eff_idx  = expire ? '0 : idx_q;
        data_d   = expire ? '0 : data_q;
        idx_d    = eff_idx;
        timer_d  = timer_q;
        complete = 1'b0;
        if (rx_ready) begin
            data_d[8*int'(eff_idx) +: 8] = rx_data;
            timer_d = '0;
            if (int'(eff_idx) == NBYTES - 1) begin
                complete = 1'b1;
                idx_d    = '0;
            end else begin
                idx_d = eff_idx + 1'b1;
            end
        end else if (expire) begin
            timer_d = '0;
        end else if (idx_q != '0) begin
            timer_d = timer_q + 1'b1;
        end
        sample = data_d;
    end

    // Assembly state registers.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            idx_q   <= '0;
            timer_q <= '0;
            data_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            timer_q <= timer_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/ecg_stream_ctrl.sv
// Feeds assembled samples to the FIR cascade, scales/saturates the result and
// serialises it back to the UART transmitter.
module ecg_stream_ctrl
    import ecg_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 64,
    parameter int unsigned SAMPLEWIDTH = 16,
    parameter int unsigned OUTSHIFT    = 31,
    parameter int unsigned FILTLAT     = 2,
    parameter int unsigned TIMEOUT     = 50000
) (
    input  logic              Clk,
    input  logic              nRst,
    ecg_stream_ctrl_if.master bus,
    output logic              overrun,
    output logic              sat,
    output logic [15:0]       drop_cnt
);
    localparam int NBYTES = int'(SAMPLEWIDTH / 8);
    localparam int IdxW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LatW   = (FILTLAT > 1) ? $clog2(FILTLAT) : 1;

    localparam logic [DATAWIDTH-1:0] SatPos = DATAWIDTH'(sat_pos(SAMPLEWIDTH));
    localparam logic [DATAWIDTH-1:0] SatNeg = DATAWIDTH'(sat_neg(SAMPLEWIDTH));

    logic [SAMPLEWIDTH-1:0] sample;
    logic                   complete;

    ecg_state_e             state_q, state_d;
    logic [DATAWIDTH-1:0]   filt_in_q, filt_in_d;
    logic [DATAWIDTH-1:0]   capt_q, capt_d;
    logic [LatW-1:0]        lat_q, lat_d;
    logic [SAMPLEWIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic                   overrun_q, overrun_d;
    logic                   sat_q, sat_d;
    logic [15:0]            drop_q, drop_d;

    logic signed [DATAWIDTH-1:0] shifted;
    logic                        sat_hi, sat_lo;
    logic [SAMPLEWIDTH-1:0]      scaled;
    logic                        sample_en;
    logic                        tx_start;
    logic [7:0]                  tx_data;

    ecg_byte_assembler #(
        .SAMPLEWIDTH (SAMPLEWIDTH),
        .TIMEOUT     (TIMEOUT)
    ) u_asm (
        .Clk      (Clk),
        .nRst     (nRst),
        .rx_data  (bus.rx_data),
        .rx_ready (bus.rx_ready),
        .sample   (sample),
        .complete (complete)
    );

    // Scale the captured filter output and clamp it to the sample range.
    always_comb begin
        shifted = $signed(capt_q) >>> OUTSHIFT;
        sat_hi  = shifted > $signed(SatPos);
        sat_lo  = shifted < $signed(SatNeg);
        if (sat_hi) begin
            scaled = SatPos[SAMPLEWIDTH-1:0];
        end else if (sat_lo) begin
            scaled = SatNeg[SAMPLEWIDTH-1:0];
        end else begin
            scaled = shifted[SAMPLEWIDTH-1:0];
        end
    end

    // Next-state logic, strobes and overrun accounting.
    always_comb begin
        state_d   = state_q;
        filt_in_d = filt_in_q;
        capt_d    = capt_q;
        lat_d     = lat_q;
        result_d  = result_q;
        ptr_d     = ptr_q;
        overrun_d = overrun_q;
        sat_d     = sat_q;
        drop_d    = drop_q;
        sample_en = 1'b0;
        tx_start  = 1'b0;
        tx_data   = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (complete) begin
                    filt_in_d = DATAWIDTH'($signed(sample));
                    state_d   = StFeed;
                end
            end
            StFeed: begin
                sample_en = 1'b1;
                lat_d     = LatW'(FILTLAT - 1);
                state_d   = StWait;
            end
            StWait: begin
                if (lat_q == '0) begin
                    capt_d  = bus.FiltOut;
                    state_d = StScale;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StScale: begin
                result_d = scaled;
                if (sat_hi || sat_lo) begin
                    sat_d = 1'b1;
                end
                ptr_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    tx_data  = result_q[8*int'(ptr_q) +: 8];
                    state_d  = StGuard;
                end
            end
            StGuard: begin
                // The transmitter may not have raised busy yet, so busy is not looked at here.
                if (int'(ptr_q) == NBYTES - 1) begin
                    state_d = StIdle;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = StSend;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A sample finishing outside Idle (including the Guard->Idle cycle) is lost.
        if (complete && (state_q != StIdle)) begin
            overrun_d = 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // Controller state registers.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= StIdle;
            filt_in_q <= '0;
            capt_q    <= '0;
            lat_q     <= '0;
            result_q  <= '0;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            filt_in_q <= filt_in_d;
            capt_q    <= capt_d;
            lat_q     <= lat_d;
            result_q  <= result_d;
            ptr_q     <= ptr_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.FiltIn    = filt_in_q;
    assign bus.sample_en = sample_en;
    assign bus.tx_start  = tx_start;
    assign bus.tx_data   = tx_data;
    assign overrun       = overrun_q;
    assign sat           = sat_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_ecg_stream_ctrl.sv
// Self-checking bench for ecg_stream_ctrl: directed scenarios plus randomised samples.
module tb_ecg_stream_ctrl;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 16;
    localparam int unsigned OS = 16;
    localparam int unsigned FL = 2;
    localparam int unsigned TO = 100;

    logic        Clk = 1'b0;
    logic        nRst = 1'b0;
    logic        overrun;
    logic        sat;
    logic [15:0] drop_cnt;

    ecg_stream_ctrl_if #(.DATAWIDTH(DW)) bus ();

    ecg_stream_ctrl #(
        .DATAWIDTH   (DW),
        .SAMPLEWIDTH (SW),
        .OUTSHIFT    (OS),
        .FILTLAT     (FL),
        .TIMEOUT     (TO)
    ) dut (
        .Clk      (Clk),
        .nRst     (nRst),
        .bus      (bus),
        .overrun  (overrun),
        .sat      (sat),
        .drop_cnt (drop_cnt)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Filter model: FL-deep register pipe; off-strobe garbage exposes a mistimed capture.
    logic [63:0] filt_src = '0;
    logic [63:0] pipe0, pipe1;
    always @(posedge Clk) begin
        pipe0 <= bus.sample_en ? filt_src : 64'hDEAD_BEEF_0BAD_F00D;
        pipe1 <= pipe0;
    end
    assign bus.FiltOut = pipe1;

    // Transmitter model: busy for 10 cycles after each start.
    int cyc = 0;
    int start_cnt = 0;
    int seen_cnt = 0;
    int busy_cnt = 0;
    int last_start = -100;
    int se_count = 0;
    logic [7:0] tx_q[$];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk) begin
        if (!nRst) begin
            busy_cnt <= 0;
            seen_cnt <= start_cnt;
        end else if (start_cnt != seen_cnt) begin
            seen_cnt <= start_cnt;
            busy_cnt <= 10;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.tx_busy = (busy_cnt != 0);

    always @(negedge Clk) begin
        if (bus.tx_start) begin
            check("tx_start_while_busy", bus.tx_busy, 0);
            check("tx_start_spacing", (cyc - last_start >= 2), 1);
            tx_q.push_back(bus.tx_data);
            last_start <= cyc;
            start_cnt  <= start_cnt + 1;
        end
        if (bus.sample_en) se_count <= se_count + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference scaler: arithmetic shift then clamp to the signed 16-bit range.
    function automatic logic [15:0] ref_scale(input logic [63:0] fo, output logic s);
        longint v;
        v = $signed(fo) >>> OS;
        s = 1'b0;
        if (v > 64'sd32767) begin
            s = 1'b1;
            return 16'h7FFF;
        end
        if (v < -64'sd32768) begin
            s = 1'b1;
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    logic sat_m = 1'b0;
    logic ovr_m = 1'b0;
    int   drop_m = 0;
    int   rd = 0;
    int   se_exp = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 400 && tx_q.size() < n; i++) tick();
    endtask

    task automatic check_tx(input logic [15:0] r);
        check("tx_count", tx_q.size(), rd + 2);
        if (tx_q.size() >= rd + 2) begin
            check("tx_byte_lo", tx_q[rd], r[7:0]);
            check("tx_byte_hi", tx_q[rd+1], r[15:8]);
        end
        rd = tx_q.size();
    endtask

    // Called right after the final byte of a sample has been presented.
    task automatic finish_sample(input logic [15:0] smp, input logic [63:0] fo);
        logic [15:0] r;
        logic        s;
        filt_src = fo;
        se_exp++;
        @(negedge Clk);
        check("sample_en_next_cycle", bus.sample_en, 1);
        check("filt_in", bus.FiltIn, {{48{smp[15]}}, smp});
        r = ref_scale(fo, s);
        sat_m = sat_m | s;
        wait_tx(rd + 2);
        check_tx(r);
        repeat (3) tick();
        check("sample_en_count", se_count, se_exp);
        check("sat", sat, sat_m);
        check("overrun", overrun, ovr_m);
        check("drop_cnt", drop_cnt, drop_m);
    endtask

    initial begin
        logic [7:0]  b0, b1;
        logic [63:0] fo;
        logic [15:0] r;
        logic        s;
        longint      lv;
        int          v;

        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        nRst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_sample_en", bus.sample_en, 0);
        check("rst_filt_in", bus.FiltIn, 0);
        check("rst_overrun", overrun, 0);
        check("rst_sat", sat, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        nRst = 1'b1;
        tick();

        // Basic assembly and in-range scaling.
        rx_byte(8'h34); rx_byte(8'h12);
        finish_sample(16'h1234, 64'h0000_0000_5678_0000);
        // Exact range edges do not saturate.
        rx_byte(8'h02); rx_byte(8'h00);
        finish_sample(16'h0002, 64'h0000_0000_7FFF_FFFF);
        rx_byte(8'h03); rx_byte(8'h80);
        finish_sample(16'h8003, 64'hFFFF_FFFF_8000_0000);
        // Negative sample, positive saturation.
        rx_byte(8'hFE); rx_byte(8'hFF);
        finish_sample(16'hFFFE, 64'h0000_0001_0000_0000);
        // Negative saturation.
        rx_byte(8'h01); rx_byte(8'h00);
        finish_sample(16'h0001, 64'hFFFF_FFFF_0000_0000);

        // Byte arriving with the idle timer at TIMEOUT-1 still belongs to the sample.
        rx_byte(8'h34);
        repeat (TO - 1) tick();
        rx_byte(8'h12);
        finish_sample(16'h1234, 64'h0000_0000_0042_0000);

        // Byte arriving as the timer expires starts a fresh sample.
        rx_byte(8'h34);
        repeat (TO) tick();
        rx_byte(8'h12); rx_byte(8'h00);
        finish_sample(16'h0012, 64'h0000_0000_0012_0000);

        // Second sample completing during SEND is dropped.
        filt_src = 64'h0000_0000_1357_0000;
        rx_byte(8'hAA); rx_byte(8'hBB);
        se_exp++;
        @(negedge Clk);
        check("ovr_sample_en", bus.sample_en, 1);
        r = ref_scale(64'h0000_0000_1357_0000, s);
        wait_tx(rd + 1);
        tick(); tick();
        rx_byte(8'h11); rx_byte(8'h22);
        ovr_m = 1'b1;
        drop_m++;
        @(negedge Clk);
        check("ovr_filt_in_kept", bus.FiltIn, 64'hFFFF_FFFF_FFFF_BBAA);
        check("ovr_flag", overrun, 1);
        check("ovr_drop_cnt", drop_cnt, 1);
        wait_tx(rd + 2);
        check_tx(r);
        repeat (15) tick();
        check("ovr_sample_en_count", se_count, se_exp);

        // Reset in GUARD of byte 0 clears everything at once.
        rx_byte(8'h05); rx_byte(8'h00);
        filt_src = 64'h0000_0000_0005_0000;
        se_exp++;
        wait_tx(rd + 1);
        nRst = 1'b0;
        #1;
        check("mid_rst_tx_start", bus.tx_start, 0);
        check("mid_rst_tx_data", bus.tx_data, 0);
        check("mid_rst_sample_en", bus.sample_en, 0);
        check("mid_rst_filt_in", bus.FiltIn, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_sat", sat, 0);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        sat_m = 1'b0; ovr_m = 1'b0; drop_m = 0;
        tick();
        nRst = 1'b1;
        repeat (3) tick();
        check("post_rst_no_tx", tx_q.size(), rd + 1);
        rd = tx_q.size();
        rx_byte(8'h01); rx_byte(8'h00);
        finish_sample(16'h0001, 64'h0000_0000_0003_0000);

        // Randomised samples against the reference scaler.
        for (int k = 0; k < 12; k++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    v  = int'($urandom_range(0, 65535)) - 32768;
                    lv = longint'(v) <<< 16;
                    fo = 64'(lv) | 64'($urandom_range(0, 65535));
                end
                1: fo = {$urandom, $urandom};
                default: begin
                    v  = int'($urandom_range(0, 2097152)) - 1048576;
                    lv = longint'(v) <<< 16;
                    fo = 64'(lv);
                end
            endcase
            rx_byte(b0); rx_byte(b1);
            finish_sample({b1, b0}, fo);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
